// File: rtl/alu_exec_if.sv
// Request/response bundle for the execute-stage ALU: operands and op code in,
// result and flags out, with a valid/ready handshake on each side.
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               InValid;
    logic               InReady;
    logic [2:0]         ALUOperation;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] Shamt;
    logic               OutValid;
    logic               OutReady;
    logic [WIDTH-1:0]   Result;
    logic               Zero;
    logic               Overflow;
    logic               Illegal;

    modport master (
        output InValid, ALUOperation, A, B, Shamt, OutReady,
        input  InReady, OutValid, Result, Zero, Overflow, Illegal
    );

    modport slave (
        input  InValid, ALUOperation, A, B, Shamt, OutReady,
        output InReady, OutValid, Result, Zero, Overflow, Illegal
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: and/or/add/sub/slt finish in one cycle, sll/srl shift one
// bit per cycle, so both sides carry a valid/ready handshake.
module alu_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic       clk,
    input logic       reset,
    alu_exec_if.slave bus
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_ILL = 3'b111
    } op_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    op_t                op;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   sh_next;
    logic [SHAMT_W-1:0] count;
    logic               shift_left;
    logic               out_valid;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ovf_q;
    logic               ill_q;

    logic               accept;
    logic               start_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    assign op          = op_t'(bus.ALUOperation);
    assign bus.InReady = (state == IDLE) || (state == DONE && bus.OutReady);
    assign accept      = bus.InValid && bus.InReady;
    // A zero-distance shift is just a pass-through of B and takes the one-cycle path.
    assign start_shift = (op == OP_SLL || op == OP_SRL) && (bus.Shamt != '0);
    assign sum         = bus.A + bus.B;
    assign diff        = bus.A - bus.B;
    assign sh_next     = shift_left ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL, OP_SRL: alu_res = bus.B;
            default: alu_res = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            count      <= '0;
            shreg      <= '0;
            shift_left <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    shreg <= sh_next;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result_q  <= sh_next;
                        zero_q    <= (sh_next == '0);
                        ovf_q     <= 1'b0;
                        ill_q     <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (start_shift) begin
                            state      <= SHIFT;
                            out_valid  <= 1'b0;
                            shreg      <= bus.B;
                            count      <= bus.Shamt;
                            shift_left <= (op == OP_SLL);
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result_q  <= alu_res;
                            zero_q    <= (alu_res == '0);
                            ovf_q     <= alu_ovf;
                            ill_q     <= (op == OP_ILL);
                        end
                    end else if (state == DONE && bus.OutReady) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.OutValid = out_valid;
    assign bus.Result   = result_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;
    assign bus.Illegal  = ill_q;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU that consumes the 3-bit ALU operation code from the ALU control decoder, together with the register-file operands and the shift amount.
- Add, sub, and, or and slt complete in one cycle.
- sll and srl use an iterative 1-bit-per-cycle shifter, so the block has valid/ready handshakes on both input and output.
- Sits between ID/EX operand delivery and the EX/MEM writeback path.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- SHAMT_W, 5, width of the shift amount; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- InValid  input  1  operation request valid.
- InReady  output  1  block can accept a request this cycle.
- ALUOperation  input  3  op code: 000 and, 001 or, 010 add, 011 sub, 100 slt, 101 sll, 110 srl, 111 illegal.
- A  input  WIDTH  operand rs.
- B  input  WIDTH  operand rt; this is the shifted operand for sll/srl.
- Shamt  input  SHAMT_W  shift amount for sll/srl; ignored for other ops.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- Result  output  WIDTH  operation result.
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow on add/sub.
- Illegal  output  1  op code 111 was executed.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately at any point, including mid-shift:
  - state = IDLE, OutValid = 0, Result = 0, Zero = 0, Overflow = 0, Illegal = 0;
  - shift counter = 0; any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- InReady = (state == IDLE) or (state == DONE and OutReady). It is combinational from state and OutReady only.
- Accept: a request is taken on a rising edge where InValid && InReady. Inputs are ignored on all other edges and are not required to stay stable after acceptance.
- Single-cycle ops (and, or, add, sub, slt, illegal) and shifts with Shamt = 0:
  - the result is registered on the accept edge and the state goes to DONE;
  - OutValid is high in the cycle immediately after the accept edge (latency 1).
- Shifts with Shamt = n > 0:
  - on the accept edge, load B into the shift register, set counter = n, and go to SHIFT;
  - on each following edge, shift by 1 (sll: left, zero fill; srl: right, logical zero fill) and decrement the counter;
  - on the edge where the counter goes 1 -> 0, go to DONE;
  - OutValid rises after accept edge + n.
  - InReady is low throughout SHIFT.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - Overflow = 1 only on add/sub when the signed result sign is inconsistent with the operand signs; it is 0 for all other ops.
  - slt is a signed two's-complement compare: Result = {WIDTH-1 zeros, (A < B)}.
  - and/or are bitwise.
  - Illegal op: Result = 0, Illegal = 1, Overflow = 0, Zero = 1.
- Zero always reflects the final Result and is registered together with it.
- DONE:
  - Result, Zero, Overflow and Illegal are held stable while OutValid && !OutReady.
  - On OutReady with no new accepted request: go to IDLE and OutValid = 0. Result and the flags keep their last value but are don't-care.
  - On OutReady with a simultaneous accepted request: the old result retires and the new op starts on the same edge.
    - Single-cycle new op: OutValid stays high, giving back-to-back 1-per-cycle throughput.
    - Shift new op with n > 0: state goes to SHIFT and OutValid drops.
- OutValid is never high in IDLE or SHIFT.
- The flags (Zero, Overflow, Illegal) are meaningful only while OutValid = 1.

Test Plan:
- add, A=0x7FFFFFFF, B=0x00000001, OutReady=1 -> next cycle OutValid=1, Result=0x80000000, Overflow=1, Zero=0.
- sub, A=5, B=5, then slt with A=0xFFFFFFFF, B=1 on the following cycle with OutReady=1 -> Result=0, Zero=1; then Result=1, Overflow=0; OutValid continuous across both ops.
- sll, B=1, Shamt=31 -> InReady=0 for the 31 SHIFT cycles; OutValid rises 31 edges after accept with Result=0x80000000. srl with B=0x80000000, Shamt=0 -> latency 1, Result=0x80000000.
- Backpressure: or, A=0xF0, B=0x0F, OutReady held 0 for 5 cycles -> Result=0xFF held stable, InReady=0; OutReady=1 -> retires, block returns to IDLE.
- reset asserted mid-shift (srl, Shamt=20, after 7 cycles) -> all outputs immediately at reset values; after release the next add (2+3) returns 5 with latency 1.
- ALUOperation=111 -> OutValid after 1 cycle with Result=0, Illegal=1, Zero=1; the following valid op clears Illegal.
